// File: rtl/db_cfg_pkg.sv
// Shared types and defaults for the debounced-button configuration controller.
// The commit FSM state encoding and the VGA configuration layout live here.
package db_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COMMIT
    } commit_state_t;

    localparam int DF_UART_W_DEF = 2;
    localparam int DF_VGA_W_DEF  = 2;
    localparam int TIMEOUT_DEF   = 1024;

    typedef struct packed {
        logic                    hs_pol;
        logic                    vs_pol;
        logic [DF_VGA_W_DEF-1:0] df_vga;
    } vga_cfg_t;

endpackage

// File: rtl/cfg_commit_fsm.sv
// Copies a shadow configuration group into its active register at a safe point,
// or after TIMEOUT cycles of waiting, pulsing upd (and forced) for one cycle.
module cfg_commit_fsm
    import db_cfg_pkg::*;
#(
    parameter int W       = 2,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] shadow,
    input  logic         safe,
    output logic [W-1:0] active,
    output logic         upd,
    output logic         forced,
    output logic         waiting
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    commit_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     active_d;
    logic             upd_d, forced_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active;
        upd_d    = 1'b0;
        forced_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (shadow != active) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (shadow == active) begin
                    state_d = IDLE;
                end else if (safe || cnt_q == CNT_LAST) begin
                    state_d  = COMMIT;
                    active_d = shadow;
                    upd_d    = 1'b1;
                    forced_d = !safe;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            active  <= '0;
            upd     <= 1'b0;
            forced  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            active  <= active_d;
            upd     <= upd_d;
            forced  <= forced_d;
        end
    end

    assign waiting = (state_q == WAIT);

endmodule

// File: rtl/db_config_ctrl.sv
// Builds a shadow configuration from debounced button rising edges and commits
// the VGA and UART groups independently at their own safe points.
module db_config_ctrl
    import db_cfg_pkg::*;
#(
    parameter int DF_UART_W = DF_UART_W_DEF,
    parameter int DF_VGA_W  = DF_VGA_W_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 HS,
    input  logic                 VS,
    input  logic                 DF_UART,
    input  logic                 DF_VGA,
    input  logic                 vga_frame_end,
    input  logic                 uart_busy,
    output logic                 cfg_hs_pol,
    output logic                 cfg_vs_pol,
    output logic [DF_VGA_W-1:0]  cfg_df_vga,
    output logic [DF_UART_W-1:0] cfg_df_uart,
    output logic                 vga_upd,
    output logic                 uart_upd,
    output logic                 vga_forced,
    output logic                 uart_forced,
    output logic                 pending
);

    logic hs_prev, vs_prev, df_uart_prev, df_vga_prev;
    logic rise_hs, rise_vs, rise_df_uart, rise_df_vga;

    logic                 sh_hs_pol, sh_vs_pol;
    logic [DF_VGA_W-1:0]  sh_df_vga;
    logic [DF_UART_W-1:0] sh_df_uart;

    logic [DF_VGA_W+1:0]  vga_active;
    logic                 vga_waiting, uart_waiting;

    assign rise_hs      = HS & ~hs_prev;
    assign rise_vs      = VS & ~vs_prev;
    assign rise_df_uart = DF_UART & ~df_uart_prev;
    assign rise_df_vga  = DF_VGA & ~df_vga_prev;

    // Prev regs track the inputs even in reset, so a button held through reset is not an edge.
    always_ff @(posedge clk) begin
        hs_prev      <= HS;
        vs_prev      <= VS;
        df_uart_prev <= DF_UART;
        df_vga_prev  <= DF_VGA;
        if (rst) begin
            sh_hs_pol  <= 1'b0;
            sh_vs_pol  <= 1'b0;
            sh_df_vga  <= '0;
            sh_df_uart <= '0;
        end else begin
            if (rise_hs)      sh_hs_pol  <= ~sh_hs_pol;
            if (rise_vs)      sh_vs_pol  <= ~sh_vs_pol;
            if (rise_df_vga)  sh_df_vga  <= sh_df_vga + 1'b1;
            if (rise_df_uart) sh_df_uart <= sh_df_uart + 1'b1;
        end
    end

    cfg_commit_fsm #(
        .W       (DF_VGA_W + 2),
        .TIMEOUT (TIMEOUT)
    ) u_vga_commit (
        .clk     (clk),
        .rst     (rst),
        .shadow  ({sh_hs_pol, sh_vs_pol, sh_df_vga}),
        .safe    (vga_frame_end),
        .active  (vga_active),
        .upd     (vga_upd),
        .forced  (vga_forced),
        .waiting (vga_waiting)
    );

    cfg_commit_fsm #(
        .W       (DF_UART_W),
        .TIMEOUT (TIMEOUT)
    ) u_uart_commit (
        .clk     (clk),
        .rst     (rst),
        .shadow  (sh_df_uart),
        .safe    (~uart_busy),
        .active  (cfg_df_uart),
        .upd     (uart_upd),
        .forced  (uart_forced),
        .waiting (uart_waiting)
    );

    assign {cfg_hs_pol, cfg_vs_pol, cfg_df_vga} = vga_active;
    assign pending = vga_waiting | uart_waiting;

endmodule

// File: tb/tb_db_config_ctrl.sv
// Directed bench for db_config_ctrl with TIMEOUT=16; inputs change 1ns after
// each rising edge and outputs are checked at that same point.
module tb_db_config_ctrl;

    localparam int DF_UART_W = 2;
    localparam int DF_VGA_W  = 2;
    localparam int TIMEOUT   = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 HS, VS, DF_UART, DF_VGA;
    logic                 vga_frame_end, uart_busy;
    logic                 cfg_hs_pol, cfg_vs_pol;
    logic [DF_VGA_W-1:0]  cfg_df_vga;
    logic [DF_UART_W-1:0] cfg_df_uart;
    logic                 vga_upd, uart_upd, vga_forced, uart_forced, pending;

    int checks = 0;
    int errors = 0;
    int vga_upd_cnt = 0, vga_forced_cnt = 0, uart_upd_cnt = 0, uart_forced_cnt = 0;
    int v0, u0, f0;

    db_config_ctrl #(
        .DF_UART_W (DF_UART_W),
        .DF_VGA_W  (DF_VGA_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .HS            (HS),
        .VS            (VS),
        .DF_UART       (DF_UART),
        .DF_VGA        (DF_VGA),
        .vga_frame_end (vga_frame_end),
        .uart_busy     (uart_busy),
        .cfg_hs_pol    (cfg_hs_pol),
        .cfg_vs_pol    (cfg_vs_pol),
        .cfg_df_vga    (cfg_df_vga),
        .cfg_df_uart   (cfg_df_uart),
        .vga_upd       (vga_upd),
        .uart_upd      (uart_upd),
        .vga_forced    (vga_forced),
        .uart_forced   (uart_forced),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    // Pulses are high from one rising edge to the next, so each is seen at exactly one falling edge.
    always @(negedge clk) begin
        if (vga_upd)     vga_upd_cnt++;
        if (vga_forced)  vga_forced_cnt++;
        if (uart_upd)    uart_upd_cnt++;
        if (uart_forced) uart_forced_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        HS = 1'b1; VS = 1'b0; DF_UART = 1'b0; DF_VGA = 1'b0;
        vga_frame_end = 1'b0; uart_busy = 1'b0; rst = 1'b1;
        ticks(3);

        // HS held through reset: no edge, nothing commits.
        rst = 1'b0;
        v0 = vga_upd_cnt;
        ticks(50);
        check("t1_hs_pol", 32'(cfg_hs_pol), 0);
        check("t1_vs_pol", 32'(cfg_vs_pol), 0);
        check("t1_df_vga", 32'(cfg_df_vga), 0);
        check("t1_df_uart", 32'(cfg_df_uart), 0);
        check("t1_pending", 32'(pending), 0);
        check("t1_no_vga_upd", 32'(vga_upd_cnt - v0), 0);
        HS = 1'b0;
        ticks(2);

        // HS rise at E0, frame end at E5.
        v0 = vga_upd_cnt;
        f0 = vga_forced_cnt;
        HS = 1'b1;
        tick();
        check("t2_pend_e0", 32'(pending), 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("t2_pend_e%0d", i), 32'(pending), 1);
        end
        check("t2_hs_pre", 32'(cfg_hs_pol), 0);
        vga_frame_end = 1'b1;
        tick();
        vga_frame_end = 1'b0;
        HS = 1'b0;
        check("t2_hs_pol", 32'(cfg_hs_pol), 1);
        check("t2_upd_hi", 32'(vga_upd), 1);
        check("t2_forced_lo", 32'(vga_forced), 0);
        check("t2_pend_e5", 32'(pending), 0);
        tick();
        check("t2_upd_lo", 32'(vga_upd), 0);
        check("t2_hs_hold", 32'(cfg_hs_pol), 1);
        check("t2_upd_count", 32'(vga_upd_cnt - v0), 1);
        check("t2_forced_count", 32'(vga_forced_cnt - f0), 0);

        // Five DF_UART presses while busy, then idle: commits 5 mod 4.
        uart_busy = 1'b1;
        u0 = uart_upd_cnt;
        for (int i = 0; i < 5; i++) begin
            DF_UART = 1'b1;
            tick();
            DF_UART = 1'b0;
            tick();
        end
        ticks(2);
        check("t3_uart_busy_hold", 32'(cfg_df_uart), 0);
        check("t3_pend_busy", 32'(pending), 1);
        uart_busy = 1'b0;
        ticks(4);
        check("t3_df_uart", 32'(cfg_df_uart), 1);
        check("t3_uart_upd_count", 32'(uart_upd_cnt - u0), 1);
        check("t3_uart_forced", 32'(uart_forced_cnt), 0);
        check("t3_df_vga", 32'(cfg_df_vga), 0);

        // VS rise with no frame end: forced commit at E17.
        v0 = vga_upd_cnt;
        VS = 1'b1;
        tick();
        VS = 1'b0;
        ticks(TIMEOUT);
        check("t4_vs_pre", 32'(cfg_vs_pol), 0);
        check("t4_no_early_upd", 32'(vga_upd_cnt - v0), 0);
        tick();
        check("t4_vs_pol", 32'(cfg_vs_pol), 1);
        check("t4_upd", 32'(vga_upd), 1);
        check("t4_forced", 32'(vga_forced), 1);
        tick();
        check("t4_upd_lo", 32'(vga_upd), 0);
        check("t4_forced_lo", 32'(vga_forced), 0);

        // Reset clears everything; HS pressed twice cancels the change.
        do_reset();
        check("t5_rst_hs", 32'(cfg_hs_pol), 0);
        check("t5_rst_vs", 32'(cfg_vs_pol), 0);
        check("t5_rst_uart", 32'(cfg_df_uart), 0);
        v0 = vga_upd_cnt;
        HS = 1'b1; tick(); HS = 1'b0; tick();
        HS = 1'b1; tick(); HS = 1'b0; ticks(3);
        check("t5_pending", 32'(pending), 0);
        vga_frame_end = 1'b1;
        tick();
        vga_frame_end = 1'b0;
        ticks(2);
        check("t5_hs_pol", 32'(cfg_hs_pol), 0);
        check("t5_no_upd", 32'(vga_upd_cnt - v0), 0);

        // Reset during WAIT drops the pending change with no pulse.
        v0 = vga_upd_cnt;
        DF_VGA = 1'b1;
        ticks(2);
        check("t6_pend_wait", 32'(pending), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_df_vga", 32'(cfg_df_vga), 0);
        check("t6_pending", 32'(pending), 0);
        check("t6_upd", 32'(vga_upd), 0);
        vga_frame_end = 1'b1;
        ticks(3);
        vga_frame_end = 1'b0;
        DF_VGA = 1'b0;
        tick();
        check("t6_df_vga_after", 32'(cfg_df_vga), 0);
        check("t6_no_upd", 32'(vga_upd_cnt - v0), 0);

        // Simultaneous rises: UART commits at E2, VGA waits for frame end at E3.
        HS = 1'b1; DF_VGA = 1'b1; DF_UART = 1'b1;
        tick();
        HS = 1'b0; DF_VGA = 1'b0; DF_UART = 1'b0;
        tick();
        tick();
        check("t7_uart", 32'(cfg_df_uart), 1);
        check("t7_uart_upd", 32'(uart_upd), 1);
        check("t7_vga_wait", 32'(cfg_df_vga), 0);
        vga_frame_end = 1'b1;
        tick();
        vga_frame_end = 1'b0;
        check("t7_vga_hs", 32'(cfg_hs_pol), 1);
        check("t7_vga_df", 32'(cfg_df_vga), 1);
        check("t7_vga_upd", 32'(vga_upd), 1);
        check("t7_uart_upd_lo", 32'(uart_upd), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/db_config_ctrl.md
Name: db_config_ctrl

Overview:
Configuration controller downstream of the button debouncer. It takes the four debounced button levels (HS, VS, DF_UART, DF_VGA) and detects their rising edges to build a shadow configuration: sync polarities plus UART and VGA data-format selectors. It commits that configuration to the VGA and UART datapaths only at safe points: VGA frame end, or UART idle. A timeout forces the commit if no safe point arrives.

Parameters:
DF_UART_W, 2, width of UART data-format selector (wraps modulo 2^DF_UART_W)
DF_VGA_W, 2, width of VGA data-format selector (wraps modulo 2^DF_VGA_W)
TIMEOUT, 1024, max WAIT cycles before forced commit (>=2)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
HS  in  1  debounced HS button level
VS  in  1  debounced VS button level
DF_UART  in  1  debounced UART-format button level
DF_VGA  in  1  debounced VGA-format button level
vga_frame_end  in  1  one-cycle pulse, last pixel of frame (VGA safe point)
uart_busy  in  1  high while UART frame in flight (safe when low)
cfg_hs_pol  out  1  committed HS polarity
cfg_vs_pol  out  1  committed VS polarity
cfg_df_vga  out  DF_VGA_W  committed VGA format
cfg_df_uart  out  DF_UART_W  committed UART format
vga_upd  out  1  one-cycle pulse: VGA group just committed
uart_upd  out  1  one-cycle pulse: UART group just committed
vga_forced  out  1  one-cycle pulse with vga_upd when commit was via timeout
uart_forced  out  1  same for UART group
pending  out  1  OR of both groups in WAIT

Behaviour:
- Reset (rst high at edge): all cfg_*, shadow regs, pulses, pending = 0. FSMs go to IDLE and counters go to 0. Edge-detect prev regs load the current input levels, so a button held through reset produces no edge.
- Edge detect: rise_X = X & ~prev_X; prev_X <= X every edge.
- Shadow update, on the same edge the rise is seen:
  - HS toggles sh_hs_pol.
  - VS toggles sh_vs_pol.
  - DF_VGA increments sh_df_vga mod 2^W.
  - DF_UART increments sh_df_uart mod 2^W.
- Groups: VGA = {hs_pol, vs_pol, df_vga}, safe = vga_frame_end. UART = {df_uart}, safe = ~uart_busy.
- Each group has an independent FSM: IDLE, WAIT, COMMIT.
  - IDLE -> WAIT when shadow != active. Timeout counter cleared.
  - WAIT, shadow == active (change cancelled) -> IDLE, no pulse.
  - WAIT, safe high -> COMMIT. active <= shadow, upd <= 1.
  - WAIT, no safe, cnt == TIMEOUT-1 -> COMMIT. active <= shadow, upd <= 1, forced <= 1.
  - WAIT, otherwise: cnt++.
  - COMMIT -> IDLE unconditionally. upd/forced deassert next edge (exactly one-cycle pulses).
- Latency: rise sampled at edge E0 -> WAIT from E1. Commit at the first edge Ek>=E2 with safe high, so cfg changes after Ek and upd is high for the cycle Ek..Ek+1. Forced commit occurs at E(1+TIMEOUT).
- Rise on the same edge as a commit: active takes the pre-update shadow, the shadow updates, and the FSM re-arms via IDLE (second commit follows).
- Multiple rises while in WAIT: only the latest shadow value is committed.
- Simultaneous rises on several buttons: all shadow fields update together. Groups commit independently.
- Reset mid-WAIT or mid-COMMIT: the reset state wins and no pulse is emitted.
- pending = (vga_state == WAIT) | (uart_state == WAIT), registered-state based.

Decomposition:
- Package db_cfg_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, COMMIT} commit_state_t
  - localparam defaults for DF widths and TIMEOUT
  - packed struct vga_cfg_t {hs_pol, vs_pol, df_vga}
- Sub-module cfg_commit_fsm #(W, TIMEOUT), instantiated twice (VGA, UART).
  - Inputs: shadow[W], safe.
  - Outputs: active[W], upd, forced, waiting.

Test Plan:
- Reset with HS=1 held, release rst -> no edge. All cfg=0, vga_upd never pulses for 50 cycles.
- HS 0->1 at E0, vga_frame_end at E5 -> cfg_hs_pol=1 after E5. vga_upd high exactly one cycle, vga_forced=0, pending high E1..E5.
- DF_UART pressed 5 times (W=2) with uart_busy=1, then uart_busy=0 -> cfg_df_uart=1 (5 mod 4). One uart_upd, cfg_df_vga unchanged.
- TIMEOUT=16, VS rise at E0, no vga_frame_end -> commit at E17. cfg_vs_pol=1, vga_upd=vga_forced=1 for one cycle.
- HS pressed twice before any frame_end -> FSM returns to IDLE. No vga_upd, cfg_hs_pol stays 0.
- DF_VGA rise, rst asserted while in WAIT -> all outputs 0 after reset edge. No vga_upd, pending=0.
